hardwired_control_unit: RTL and testbench
=========================================

Name: hardwired_control_unit

Overview:
- Hardwired Moore control sequencer: the generator side of the datapath control-signal interface.
- Drives the datapath's control inputs cycle by cycle, decodes the IR opcode, and sequences fetch/execute for the supported instruction subset.
- Sits beside the datapath. Datapath control inputs not listed here (Zhighout, HIout, LOout, HiIn, LoIn, CIn, InIn, OutIn, CONIn, IN_Portout, multiply, divide) are tied low at integration.

Parameters:
- OP_W, 5, opcode width, taken from ir[31:27].
- HALT_ON_ILLEGAL, 0: 1 means an undefined opcode halts; 0 means it executes as nop.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  reset; synchronous, active-high.
- ir  in  32  instruction register contents; fields ir[31:27] op, ir[26:23] ra, ir[22:19] rb, ir[18:15] rc.
- mem_ready  in  1  memory completion; high in the cycle a read or write completes.
- PCout, Zlowout, MDRout, Cout, Rout, BAout  out  1 each  bus drive selects.
- MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, RIn  out  1 each  register load enables.
- IncPC, read, write  out  1 each  PC increment and memory strobes.
- Gra, Grb, Grc  out  1 each  register-field selects.
- add, subtract, andSignal, orSignal  out  1 each  ALU function, one-hot.
- run  out  1  high while executing; low in RESET and HALT.

Behaviour:
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, nop 11010, halt 11011.
- States: RESET, T0..T7, HALT.
- Outputs are a combinational decode of the registered state plus ir[31:27]. Any signal not listed for a state is 0.
- Reset:
  - clr sampled high moves to RESET regardless of state; clr has priority over mem_ready and over the halt transition.
  - In RESET all outputs are 0, including run.
  - The first edge with clr low moves RESET to T0.
- Fetch:
  - T0: PCout, MARIn, IncPC, ZIn.
  - T1: Zlowout, MDRIn, read. PCIn is asserted only in the cycle mem_ready=1. T1 holds until mem_ready=1.
  - T2: MDRout, IRIn.
  - Decode happens at T2 exit: nop or illegal (HALT_ON_ILLEGAL=0) goes to T0; halt goes to HALT; all others go to T3.
- Reg-reg add/sub/and/or:
  - T3: Grb, Rout, YIn.
  - T4: Grc, Rout, ZIn, plus the ALU function.
  - T5: Zlowout, Gra, RIn, then T0.
- Immediate addi/andi/ori:
  - T3: Grb, Rout, YIn.
  - T4: Cout, ZIn, plus the ALU function (add/andSignal/orSignal).
  - T5: Zlowout, Gra, RIn, then T0.
- ldi: T3 Grb, BAout, YIn; T4 Cout, add, ZIn; T5 Zlowout, Gra, RIn, then T0.
- ld:
  - T3: Grb, BAout, YIn. T4: Cout, add, ZIn. T5: Zlowout, MARIn.
  - T6: read, MDRIn; holds until mem_ready=1.
  - T7: MDRout, Gra, RIn, then T0.
- st:
  - T3/T4/T5 as for ld.
  - T6: Gra, Rout, MDRIn.
  - T7: MDRout, write; holds until mem_ready=1, then T0.
- ALU function signals are asserted only in T4; at most one is high in any cycle.
- read and write are never high together.
- HALT: run=0, all other outputs 0; stays in HALT until clr.
- Latency with no wait states:
  - nop: 3 cycles.
  - ALU/immediate/ldi: 6 cycles.
  - ld/st: 8 cycles.
  - Each extra cycle with mem_ready low in T1/T6(ld)/T7(st) adds one cycle.
- mem_ready is ignored outside the T1 / T6 (ld) / T7 (st) wait states.

Test Plan:
- ori R3,R4,0x25 (ir=0x71A00025), mem_ready tied 1:
  - T3: Grb/Rout/YIn.
  - T4: orSignal/Cout/ZIn.
  - T5: Zlowout/Gra/RIn.
  - Back to T0 after 6 cycles; no other ALU signal high.
- add R1,R2,R3 (ir=0x18918000):
  - T4 shows Grc/Rout/add/ZIn.
  - subtract/andSignal/orSignal stay 0 throughout.
- ld R1,0x10(R2) (ir=0x00900010), mem_ready low 3 cycles in T1 and 2 cycles in T6:
  - Instruction takes 13 cycles.
  - PCIn is high in exactly one cycle.
  - T7 shows MDRout/Gra/RIn.
- st (ir=0x10900010), mem_ready low 1 cycle in T7:
  - write held 2 cycles.
  - read is 0 throughout T3–T7.
  - Returns to T0.
- halt (ir=0xD8000000):
  - After T2, run=0 and all outputs 0 for 20 cycles with mem_ready toggling.
  - clr pulse returns to RESET then T0.
- clr asserted during T4 of add:
  - The next cycle is RESET with all outputs 0, including ZIn and add.
  - Fetch restarts at T0 one cycle after clr drops.

Source files
------------

// File: rtl/hardwired_control_unit.sv
// Moore control sequencer for the datapath: fetch T0-T2, then decode into
// reg-reg, immediate, ldi, ld or st execute sequences (T3-T7), plus HALT.
module hardwired_control_unit #(
  parameter int OP_W            = 5,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout, Zlowout, MDRout, Cout, Rout, BAout,
  output logic        MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, RIn,
  output logic        IncPC, read, write,
  output logic        Gra, Grb, Grc,
  output logic        add, subtract, andSignal, orSignal,
  output logic        run
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001,
                              OP_ST   = 5'b00010, OP_ADD  = 5'b00011,
                              OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
                              OP_OR   = 5'b00110, OP_ADDI = 5'b01100,
                              OP_ANDI = 5'b01101, OP_ORI  = 5'b01110,
                              OP_NOP  = 5'b11010, OP_HALT = 5'b11011;

  state_t          state_q, state_d;
  logic [OP_W-1:0] op;
  logic            is_ld, is_st, is_ldi, is_rr, is_imm, is_exec;
  logic            fn_add, fn_sub, fn_and, fn_or;
  logic            unused_ir;

  assign op        = ir[31 -: OP_W];
  assign unused_ir = ^ir[31-OP_W:0];

  assign is_ld   = (op == OP_LD);
  assign is_st   = (op == OP_ST);
  assign is_ldi  = (op == OP_LDI);
  assign is_rr   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign is_imm  = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  assign is_exec = is_ld || is_st || is_ldi || is_rr || is_imm;

  // Address arithmetic for ld/ldi/st reuses the adder.
  assign fn_add = (op == OP_ADD) || (op == OP_ADDI) || is_ld || is_ldi || is_st;
  assign fn_sub = (op == OP_SUB);
  assign fn_and = (op == OP_AND) || (op == OP_ANDI);
  assign fn_or  = (op == OP_OR)  || (op == OP_ORI);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = mem_ready ? S_T2 : S_T1;
      S_T2: begin
        if (op == OP_HALT)     state_d = S_HALT;
        else if (is_exec)      state_d = S_T3;
        else if (op == OP_NOP) state_d = S_T0;
        else                   state_d = HALT_ON_ILLEGAL ? S_HALT : S_T0;
      end
      S_T3:    state_d = S_T4;
      S_T4:    state_d = S_T5;
      S_T5:    state_d = (is_ld || is_st) ? S_T6 : S_T0;
      S_T6:    state_d = (is_ld && !mem_ready) ? S_T6 : S_T7;
      S_T7:    state_d = (is_st && !mem_ready) ? S_T7 : S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  always_comb begin
    {PCout, Zlowout, MDRout, Cout, Rout, BAout}    = '0;
    {MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, RIn}      = '0;
    {IncPC, read, write, Gra, Grb, Grc}            = '0;
    {add, subtract, andSignal, orSignal}           = '0;
    run = (state_q != S_RESET) && (state_q != S_HALT);
    unique case (state_q)
      S_T0: begin PCout = 1'b1; MARIn = 1'b1; IncPC = 1'b1; ZIn = 1'b1; end
      S_T1: begin Zlowout = 1'b1; MDRIn = 1'b1; read = 1'b1; PCIn = mem_ready; end
      S_T2: begin MDRout = 1'b1; IRIn = 1'b1; end
      S_T3: begin
        Grb = 1'b1; YIn = 1'b1;
        BAout = is_ld || is_st || is_ldi;
        Rout  = !(is_ld || is_st || is_ldi);
      end
      S_T4: begin
        ZIn = 1'b1;
        Grc = is_rr; Rout = is_rr; Cout = !is_rr;
        add = fn_add; subtract = fn_sub; andSignal = fn_and; orSignal = fn_or;
      end
      S_T5: begin
        Zlowout = 1'b1;
        MARIn = is_ld || is_st;
        Gra   = !(is_ld || is_st);
        RIn   = !(is_ld || is_st);
      end
      S_T6: begin
        MDRIn = 1'b1;
        read  = is_ld;
        Gra   = !is_ld; Rout = !is_ld;
      end
      S_T7: begin
        MDRout = 1'b1;
        write  = is_st;
        Gra    = !is_st; RIn = !is_st;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hardwired_control_unit.sv
// Randomised bench: a micro-step table model of each instruction predicts the
// full control word every cycle, including wait states, halt and clr.
module tb_hardwired_control_unit;
  logic        clk = 1'b0;
  logic        clr, mem_ready;
  logic [31:0] ir;
  logic PCout, Zlowout, MDRout, Cout, Rout, BAout, MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, RIn;
  logic IncPC, read, write, Gra, Grb, Grc, add, subtract, andSignal, orSignal, run;

  hardwired_control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .Rout(Rout), .BAout(BAout),
    .MARIn(MARIn), .PCIn(PCIn), .MDRIn(MDRIn), .IRIn(IRIn), .YIn(YIn), .ZIn(ZIn), .RIn(RIn),
    .IncPC(IncPC), .read(read), .write(write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .add(add), .subtract(subtract), .andSignal(andSignal), .orSignal(orSignal), .run(run)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] PCO = 24'd1 << 23, ZLO = 24'd1 << 22, MDO = 24'd1 << 21, CO  = 24'd1 << 20;
  localparam logic [23:0] RO  = 24'd1 << 19, BAO = 24'd1 << 18, MAI = 24'd1 << 17, PCI = 24'd1 << 16;
  localparam logic [23:0] MDI = 24'd1 << 15, IRI = 24'd1 << 14, YI  = 24'd1 << 13, ZI  = 24'd1 << 12;
  localparam logic [23:0] RI  = 24'd1 << 11, INC = 24'd1 << 10, RD  = 24'd1 << 9,  WR  = 24'd1 << 8;
  localparam logic [23:0] GA  = 24'd1 << 7,  GB  = 24'd1 << 6,  GC  = 24'd1 << 5,  FADD = 24'd1 << 4;
  localparam logic [23:0] FSUB = 24'd1 << 3, FAND = 24'd1 << 2, FOR = 24'd1 << 1,  RUN = 24'd1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %06h expected %06h (diff %06h) at %0t", tag, got, exp, got ^ exp, $time);
    end
  endtask

  // Model: 0 reset, 1 running a step list, 2 halted.
  int          mode;
  logic [23:0] qw[$];
  bit          qwt[$];
  int          idx;
  bit          in_fetch;

  task automatic load_fetch();
    qw  = '{PCO|MAI|INC|ZI|RUN, ZLO|MDI|RD|RUN, MDO|IRI|RUN};
    qwt = '{1'b0, 1'b1, 1'b0};
    idx = 0; in_fetch = 1'b1;
  endtask

  task automatic decode(input logic [4:0] op);
    logic [23:0] fn, x3, x4;
    fn = (op == 5'd3 || op == 5'd12) ? FADD : (op == 5'd4) ? FSUB :
         (op == 5'd5 || op == 5'd13) ? FAND : FOR;
    idx = 0; in_fetch = 1'b0;
    x3 = GB|BAO|YI|RUN; x4 = CO|FADD|ZI|RUN;
    case (op)
      5'd27: mode = 2;
      5'd0: begin
        qw = '{x3, x4, ZLO|MAI|RUN, RD|MDI|RUN, MDO|GA|RI|RUN}; qwt = '{0, 0, 0, 1, 0};
      end
      5'd2: begin
        qw = '{x3, x4, ZLO|MAI|RUN, GA|RO|MDI|RUN, MDO|WR|RUN}; qwt = '{0, 0, 0, 0, 1};
      end
      5'd1: begin qw = '{x3, x4, ZLO|GA|RI|RUN}; qwt = '{0, 0, 0}; end
      5'd3, 5'd4, 5'd5, 5'd6: begin
        qw = '{GB|RO|YI|RUN, GC|RO|ZI|fn|RUN, ZLO|GA|RI|RUN}; qwt = '{0, 0, 0};
      end
      5'd12, 5'd13, 5'd14: begin
        qw = '{GB|RO|YI|RUN, CO|ZI|fn|RUN, ZLO|GA|RI|RUN}; qwt = '{0, 0, 0};
      end
      default: load_fetch();
    endcase
  endtask

  logic [4:0]  legal[12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14, 5'd26, 5'd27};
  logic [31:0] directed[$] = '{32'h71A00025, 32'h18918000, 32'h00900010, 32'h10900010, 32'hD8000000};

  logic [23:0] got, exp;
  int          halt_cnt;
  string       tag;

  initial begin
    clr = 1'b1; mem_ready = 1'b0; ir = 32'h0;
    mode = 0; idx = 0; in_fetch = 1'b1; halt_cnt = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      clr = (cyc < 3) || (halt_cnt > 20) || ($urandom_range(0, 79) == 0);
      mem_ready = (cyc < 400) ? (cyc % 7 != 3) : ($urandom_range(0, 2) != 0);
      if (mode != 1 || (in_fetch && idx == 0)) begin
        if (directed.size() > 0 && mode == 1) ir = directed.pop_front();
        else if ($urandom_range(0, 15) < 12) ir = {legal[$urandom_range(0, 11)], 27'($urandom)};
        else ir = $urandom;
      end
      #1;
      got = {PCout, Zlowout, MDRout, Cout, Rout, BAout, MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, RIn,
             IncPC, read, write, Gra, Grb, Grc, add, subtract, andSignal, orSignal, run};
      if (mode == 1) begin
        exp = qw[idx];
        if (in_fetch && idx == 1 && mem_ready) exp |= PCI;
        tag = $sformatf("%s_step%0d_op%0d", in_fetch ? "fetch" : "exec", idx, ir[31:27]);
      end else begin
        exp = '0;
        tag = (mode == 0) ? "reset" : "halt";
      end
      chk(tag, got, exp);
      @(posedge clk);
      if (clr) begin
        mode = 0; halt_cnt = 0;
      end else if (mode == 0) begin
        mode = 1; load_fetch();
      end else if (mode == 2) begin
        halt_cnt++;
      end else if (!(qwt[idx] && !mem_ready)) begin
        idx++;
        if (idx == qw.size()) begin
          if (in_fetch) decode(ir[31:27]);
          else load_fetch();
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
